// File: rtl/tap_mac.sv
// -----------------------------------------------------------------------------
// tap_mac
// Sequential multiply-accumulate stage fed by a shift register's parallel taps.
// A start request snapshots all taps and coefficients. The stage then folds in
// one signed product per clock and publishes the full-precision dot product
// together with a one-cycle valid pulse.
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   reset         synchronous active-high reset
//   start         request a new dot product (honoured in IDLE and DONE only)
//   taps          LENGTH signed taps, DATA_WIDTH bits each
//   coeffs        LENGTH signed coefficients, DATA_WIDTH bits each
//   busy          high while accumulating (RUN state)
//   result_valid  one-cycle pulse in the cycle result is updated (DONE state)
//   result        last completed dot product, ACC_WIDTH bits signed
// -----------------------------------------------------------------------------
module tap_mac #(
   parameter int DATA_WIDTH = 8,
   parameter int LENGTH     = 4,
   localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(LENGTH)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] taps   [0:LENGTH-1],
   input  logic signed [DATA_WIDTH-1:0] coeffs [0:LENGTH-1],
   output logic                         busy,
   output logic                         result_valid,
   output logic signed [ACC_WIDTH-1:0]  result
);

   localparam int IDX_W  = $clog2(LENGTH);
   localparam int PROD_W = 2*DATA_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH-1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                       state_reg;
   state_t                       state_next;
   logic                         accept;
   logic                         last;
   logic [IDX_W-1:0]             idx_reg;
   logic signed [ACC_WIDTH-1:0]  acc_reg;
   logic signed [ACC_WIDTH-1:0]  result_reg;
   logic signed [DATA_WIDTH-1:0] snap_tap_reg  [0:LENGTH-1];
   logic signed [DATA_WIDTH-1:0] snap_coef_reg [0:LENGTH-1];

   logic signed [DATA_WIDTH-1:0] tap_sel;
   logic signed [DATA_WIDTH-1:0] coef_sel;
   logic signed [PROD_W-1:0]     product;
   logic signed [ACC_WIDTH-1:0]  product_ext;
   logic signed [ACC_WIDTH-1:0]  acc_sum;

   // One multiplier shared across all taps; idx_reg walks the snapshot.
   assign tap_sel  = snap_tap_reg[idx_reg];
   assign coef_sel = snap_coef_reg[idx_reg];

   // Both operands are widened as signed values first so the multiply is a
   // true signed full-width product.
   assign product     = PROD_W'(tap_sel) * PROD_W'(coef_sel);
   assign product_ext = ACC_WIDTH'(product);
   assign acc_sum     = acc_reg + product_ext;

   assign last = (idx_reg == LAST_IDX);

   // Outputs are decodes of the state register only, so nothing on the
   // input side reaches them combinationally.
   assign busy         = (state_reg == RUN);
   assign result_valid = (state_reg == DONE);
   assign result       = result_reg;

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // Re-accepting here gives back-to-back throughput.
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         idx_reg    <= '0;
         acc_reg    <= '0;
         result_reg <= '0;
         for (int i = 0; i < LENGTH; i++) begin
            snap_tap_reg[i]  <= '0;
            snap_coef_reg[i] <= '0;
         end
      end else begin
         state_reg <= state_next;
         if (accept) begin
            idx_reg <= '0;
            acc_reg <= '0;
            for (int i = 0; i < LENGTH; i++) begin
               snap_tap_reg[i]  <= taps[i];
               snap_coef_reg[i] <= coeffs[i];
            end
         end else if (state_reg == RUN) begin
            acc_reg <= acc_sum;
            if (last) begin
               result_reg <= acc_sum;
               idx_reg    <= '0;
            end else begin
               idx_reg <= idx_reg + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_tap_mac.sv
// -----------------------------------------------------------------------------
// tb_tap_mac
// Self-checking bench for tap_mac. The driver models the block as "ready from
// cycle N", computes each dot product with integer arithmetic at the moment a
// start is accepted, and queues the value with the cycle it must appear in.
// A negedge monitor pops the queue whenever result_valid is seen and also
// checks busy and the held result every cycle.
// -----------------------------------------------------------------------------
module tb_tap_mac;

   localparam int DW = 8;
   localparam int L  = 4;
   localparam int AW = 2*DW + $clog2(L);

   logic                 clk   = 1'b0;
   logic                 reset = 1'b1;
   logic                 start = 1'b0;
   logic signed [DW-1:0] taps   [0:L-1];
   logic signed [DW-1:0] coeffs [0:L-1];
   logic                 busy;
   logic                 result_valid;
   logic signed [AW-1:0] result;

   tap_mac #(
      .DATA_WIDTH(DW),
      .LENGTH    (L)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .taps        (taps),
      .coeffs      (coeffs),
      .busy        (busy),
      .result_valid(result_valid),
      .result      (result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   exp_t exp_q[$];

   int n_checks     = 0;
   int n_pass       = 0;
   int run_lo       = 1;
   int run_hi       = 0;
   int ready_cyc    = 0;
   int model_result = 0;
   bit mon_en       = 1'b0;
   bit rst_prev     = 1'b0;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
   endtask

   function automatic int dot();
      int s = 0;
      for (int i = 0; i < L; i++) s += int'(taps[i]) * int'(coeffs[i]);
      return s;
   endfunction

   task automatic set_taps(input int a, input int b, input int c, input int d);
      taps[0] = DW'(a); taps[1] = DW'(b); taps[2] = DW'(c); taps[3] = DW'(d);
   endtask

   task automatic set_coefs(input int a, input int b, input int c, input int d);
      coeffs[0] = DW'(a); coeffs[1] = DW'(b); coeffs[2] = DW'(c); coeffs[3] = DW'(d);
   endtask

   // Drive one cycle's inputs (called #1 after a rising edge) and update the
   // reference model, then advance to #1 after the next rising edge.
   task automatic step(input logic s, input logic r);
      start = s;
      reset = r;
      if (r) begin
         if (run_hi > cyc) run_hi = cyc;
         while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
         ready_cyc = cyc + 1;
      end else if (s && cyc >= ready_cyc) begin
         exp_q.push_back('{dot(), cyc + L + 1});
         run_lo    = cyc + 1;
         run_hi    = cyc + L;
         ready_cyc = cyc + L + 1;
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         automatic exp_t e;
         automatic logic exp_busy;
         if (rst_prev) model_result = 0;
         exp_busy = (cyc >= run_lo && cyc <= run_hi);
         chk("busy", busy, exp_busy);
         if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", result_valid, 0);
            end else begin
               e = exp_q.pop_front();
               $display("result cycle %0d value %0d (expected cycle %0d value %0d)",
                        cyc, result, e.cyc, e.val);
               chk("valid_cycle", cyc, e.cyc);
               chk("result_value", result, e.val);
               model_result = e.val;
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("valid_pulse", result_valid, 1);
            model_result = e.val;
         end else begin
            chk("valid_low", result_valid, 0);
         end
         chk("result_hold", result, model_result);
      end
      rst_prev = reset;
   end

   initial begin
      set_taps(0, 0, 0, 0);
      set_coefs(0, 0, 0, 0);
      @(posedge clk);
      #1;
      step(0, 1);
      mon_en = 1'b1;
      step(0, 1);
      step(0, 0);
      chk("reset_result", result, 0);
      chk("reset_busy", busy, 0);

      // Basic dot product
      set_taps(1, 2, 3, 4); set_coefs(1, 1, 1, 1);
      step(1, 0);
      repeat (7) step(0, 0);
      chk("basic_result", result, 10);

      // Signed extremes
      set_taps(-128, -128, -128, -128); set_coefs(-128, -128, -128, -128);
      step(1, 0);
      repeat (6) step(0, 0);
      chk("extreme_neg", result, 65536);
      set_taps(127, -128, 127, -128); set_coefs(127, 127, -128, -128);
      step(1, 0);
      repeat (6) step(0, 0);
      chk("extreme_mix", result, 1);

      // Snapshot isolation and start ignored during RUN
      set_taps(1, 2, 3, 4); set_coefs(2, 2, 2, 2);
      step(1, 0);
      step(0, 0);
      set_taps(9, 9, 9, 9);
      step(1, 0);
      repeat (6) step(0, 0);
      chk("snapshot_result", result, 20);

      // Back-to-back with start held high
      set_taps(1, 2, 3, 4); set_coefs(1, 1, 1, 1);
      repeat (4) step(1, 0);
      set_coefs(-1, -1, -1, -1);
      repeat (6) step(1, 0);
      repeat (7) step(0, 0);
      chk("b2b_result", result, -10);

      // Reset mid-operation, then restart
      set_taps(5, 6, 7, 8); set_coefs(3, 3, 3, 3);
      step(1, 0);
      repeat (2) step(0, 0);
      step(0, 1);
      chk("abort_result", result, 0);
      chk("abort_busy", busy, 0);
      step(0, 0);
      set_taps(1, 2, 3, 4); set_coefs(1, 1, 1, 1);
      step(1, 0);
      repeat (7) step(0, 0);
      chk("restart_result", result, 10);

      // Reset and start together
      step(1, 1);
      chk("collision_busy", busy, 0);
      step(0, 0);
      chk("collision_idle", busy, 0);

      // Randomized traffic, operands changing every cycle
      for (int it = 0; it < 400; it++) begin
         for (int i = 0; i < L; i++) begin
            case ($urandom_range(0, 3))
               0:       taps[i] = -8'sd128;
               1:       taps[i] = 8'sd127;
               default: taps[i] = DW'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 3))
               0:       coeffs[i] = -8'sd128;
               1:       coeffs[i] = 8'sd127;
               default: coeffs[i] = DW'($urandom_range(0, 255));
            endcase
         end
         step($urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
      end

      repeat (L + 3) step(0, 0);
      chk("drain_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tap_mac.md
# tap_mac

Sequential multiply-accumulate stage that sits directly downstream of the shift register and consumes its parallel tap outputs. On a start pulse it snapshots the LENGTH signed taps and LENGTH signed coefficients. It then accumulates one product per clock and delivers the full-precision dot product with a one-cycle valid pulse. Typical use is one FIR output sample or one correlation value per shift-register update.

## Interface

Parameters:
- DATA_WIDTH, 8, width of each signed tap and coefficient.
- LENGTH, 4, number of taps and coefficients (≥ 2).
- Derived localparam ACC_WIDTH = 2*DATA_WIDTH + $clog2(LENGTH). This is 18 for the defaults.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new dot product. Sampled only when the block is ready to accept one (see Operation).
- taps  in  signed [DATA_WIDTH-1:0] [0:LENGTH-1]  parallel taps, driven from the shift register's data_out.
- coeffs  in  signed [DATA_WIDTH-1:0] [0:LENGTH-1]  coefficient set.
- busy  out  1  high while accumulating.
- result_valid  out  1  one-cycle pulse when result is updated.
- result  out  signed [ACC_WIDTH-1:0]  last completed dot product.

## Operation

- States: IDLE, RUN, DONE.
- Reset (reset=1 at an edge) takes effect from any state:
  - state to IDLE.
  - busy=0, result_valid=0, result=0.
  - Accumulator, index and snapshot registers cleared.
- IDLE, start=1: snapshot taps and coeffs into internal registers, acc=0, idx=0, go to RUN. busy=1 from the next cycle.
- IDLE, start=0: hold.
- RUN, each edge: acc += snap_tap[idx] * snap_coef[idx], idx++.
  - On the edge where idx==LENGTH-1: result <= acc + product, result_valid=1, busy=0, go to DONE.
- DONE: lasts exactly one cycle; result_valid=1 during it.
  - start=1 in DONE is accepted exactly as in IDLE (new snapshot, go to RUN). This allows back-to-back operation.
  - Otherwise go to IDLE.
- start during RUN is ignored. It is neither queued nor able to disturb the snapshot.
- taps/coeffs changes after the snapshot edge have no effect on the result in progress.
- Arithmetic:
  - Each product is a full signed DATA_WIDTH×DATA_WIDTH → 2*DATA_WIDTH multiply, sign-extended to ACC_WIDTH.
  - Accumulation is in ACC_WIDTH. No saturation or rounding; overflow is impossible by construction.
- result holds its value between completions, including through IDLE and RUN. Only reset or a new completion changes it.

## Timing

- Take the cycle where start=1 is sampled in IDLE/DONE as cycle 0.
  - busy=1 in cycles 1..LENGTH.
  - result_valid=1 and the new result appear in cycle LENGTH+1, which is 5 for the defaults.
- Latency from start to result_valid: LENGTH+1 cycles.
- Throughput: one result per LENGTH+1 cycles with start held high continuously, since start is re-accepted in the DONE cycle.
- Reset asserted mid-RUN aborts the computation: no result_valid pulse and result=0 in the cycle after the reset edge.
- Reset and start both high at the same edge: reset wins and the block stays in IDLE.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Basic dot product, driven with the shift register's parallel-load pattern:
  - Stimulus: taps={1,2,3,4}, coeffs={1,1,1,1}, start pulse in cycle 0.
  - Required: busy=1 in cycles 1-4; result_valid pulse in cycle 5 only; result=10, held afterwards.
- Signed extremes:
  - Stimulus: taps all -128, coeffs all -128.
  - Required: result=65536.
  - Stimulus: taps={127,-128,127,-128}, coeffs={127,127,-128,-128}.
  - Required: result=1.
- Snapshot isolation:
  - Stimulus: start with taps={1,2,3,4}, coeffs={2,2,2,2}. In cycle 2 change taps to {9,9,9,9} and pulse start.
  - Required: result=20; the second start is ignored (no second result_valid).
- Back-to-back:
  - Stimulus: hold start=1 continuously with taps={1,2,3,4} and coeffs={1,1,1,1}. Before the DONE cycle, change coeffs to {-1,-1,-1,-1}.
  - Required: result_valid in cycles 5 and 10; results 10 then -10.
- Reset mid-operation:
  - Stimulus: start in cycle 0, reset=1 in cycle 3.
  - Required: busy=0 and result=0 from cycle 4; no result_valid pulse.
  - Follow-up: start in cycle 6 with taps={1,2,3,4} and coeffs={1,1,1,1}.
  - Required: result=10 with result_valid in cycle 11.
- Reset/start collision:
  - Stimulus: reset=1 and start=1 in the same cycle.
  - Required: busy stays 0 and the block remains in IDLE.
